atmega_pio_pcint: RTL and testbench

Parametrised ATmega-compatible GPIO port with input synchronisation, PORT toggle via PIN write, and pin-change interrupt (PCMSK/PCIF). It is the next-generation PIO and sits on the CPU I/O bus next to the other peripherals. It drives the pad tri-state outputs and raises one interrupt request per port toward the interrupt controller.

---
 rtl/atmega_pio_pcint.sv | 167 ++++++++++++++++
 tb/tb_atmega_pio_pcint.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/atmega_pio_pcint.sv
// ---------------------------------------------------------------------------
// atmega_pio_pcint
//
// This is an ATmega-style GPIO port. It sits on the CPU I/O bus and provides
// the PORT, DDR and PIN registers. Writing to PIN toggles bits in PORT.
// Pad inputs pass through a two-flop synchroniser. A pin-change interrupt
// raises one level-sensitive request per port.
//
// Optional feature macro: ATMEGA_PIO_PCINT_EN
//   defined   -> PCMSK, PCIF and the irq path are present
//   undefined -> the PCMSK and PCIFR addresses read 0 and ignore writes,
//                irq is tied to 0, and irq_ack is ignored
//
// Ports:
//   clk                 system clock; all state changes on the rising edge
//   rst                 asynchronous reset, active low
//   addr                I/O bus address
//   wr / rd             write and read strobes
//   bus_in              write data
//   bus_out             read data; combinational, 0 when no register is read
//   io_in               raw asynchronous pad inputs
//   io_out              pad outputs; z where the pin is not driven
//   pio_out_io_connect  per-pin output enable
//   irq                 pin-change interrupt request (level)
//   irq_ack             one-cycle acknowledge; clears the pending flag
// ---------------------------------------------------------------------------
module atmega_pio_pcint #(
    parameter int PORT_WIDTH = 8,
    parameter int BUS_ADDR_DATA_LEN = 8,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] PORT_OUT_ADDR = 'h20,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] DDR_ADDR = 'h23,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] PIN_ADDR = 'h24,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] PCMSK_ADDR = 'h25,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] PCIFR_ADDR = 'h26,
    parameter logic [PORT_WIDTH-1:0] PINMASK = 'hFF,
    parameter logic [PORT_WIDTH-1:0] INVERSE_MASK = 'h0,
    parameter logic [PORT_WIDTH-1:0] OUT_ENABLED_MASK = 'hFF,
    parameter logic [PORT_WIDTH-1:0] INITIAL_OUTPUT_VALUE = 'h00
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
    input  logic                         wr,
    input  logic                         rd,
    input  logic [PORT_WIDTH-1:0]        bus_in,
    output logic [PORT_WIDTH-1:0]        bus_out,
    input  logic [PORT_WIDTH-1:0]        io_in,
    output logic [PORT_WIDTH-1:0]        io_out,
    output logic [PORT_WIDTH-1:0]        pio_out_io_connect,
    output logic                         irq,
    input  logic                         irq_ack
);

    // Wider ports occupy several byte addresses. The low address bits
    // select a byte lane, so they are left out of the register decode.
    localparam int S = (PORT_WIDTH == 32) ? 2 : ((PORT_WIDTH == 16) ? 1 : 0);

    logic [PORT_WIDTH-1:0] port_q;
    logic [PORT_WIDTH-1:0] ddr_q;
    logic [PORT_WIDTH-1:0] sync1_q;
    logic [PORT_WIDTH-1:0] pin_q;
    logic [PORT_WIDTH-1:0] pcmsk_q;
    logic                  pcif_q;

    logic sel_port;
    logic sel_ddr;
    logic sel_pin;
    logic sel_pcmsk;
    logic sel_pcifr;

    assign sel_port  = (addr[BUS_ADDR_DATA_LEN-1:S] == PORT_OUT_ADDR[BUS_ADDR_DATA_LEN-1:S]);
    assign sel_ddr   = (addr[BUS_ADDR_DATA_LEN-1:S] == DDR_ADDR[BUS_ADDR_DATA_LEN-1:S]);
    assign sel_pin   = (addr[BUS_ADDR_DATA_LEN-1:S] == PIN_ADDR[BUS_ADDR_DATA_LEN-1:S]);
    assign sel_pcmsk = (addr[BUS_ADDR_DATA_LEN-1:S] == PCMSK_ADDR[BUS_ADDR_DATA_LEN-1:S]);
    assign sel_pcifr = (addr[BUS_ADDR_DATA_LEN-1:S] == PCIFR_ADDR[BUS_ADDR_DATA_LEN-1:S]);

    // The low address bits are only needed for byte-lane selection.
    // In builds without the interrupt feature, irq_ack is also unused.
    logic unused_bits;
    assign unused_bits = ^{addr, irq_ack};

    // Core GPIO state: the input synchroniser, DDR, and PORT.
    // A PIN write does not change PIN. It XORs the written bits into PORT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            port_q  <= INITIAL_OUTPUT_VALUE;
            ddr_q   <= '0;
            sync1_q <= '0;
            pin_q   <= '0;
        end else begin
            sync1_q <= io_in;
            pin_q   <= sync1_q;
            if (wr && sel_ddr) begin
                ddr_q <= bus_in & PINMASK;
            end
            if (wr && sel_port) begin
                port_q <= bus_in & PINMASK;
            end else if (wr && sel_pin) begin
                port_q <= port_q ^ (bus_in & PINMASK);
            end
        end
    end

`ifdef ATMEGA_PIO_PCINT_EN
    logic [PORT_WIDTH-1:0] pin_d_q;
    logic                  change_event;
    logic                  pcif_clear;

    // Changes are detected on the raw synchronised level, before
    // inversion. The old PCMSK is used when a mask write coincides with
    // the change.
    assign change_event = |((pin_q ^ pin_d_q) & pcmsk_q & PINMASK);
    assign pcif_clear   = irq_ack || (wr && sel_pcifr && bus_in[0]);

    // Interrupt state. If a new change arrives in the same cycle as an
    // acknowledge, the flag stays set so that the change is not lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pin_d_q <= '0;
            pcmsk_q <= '0;
            pcif_q  <= 1'b0;
        end else begin
            pin_d_q <= pin_q;
            if (wr && sel_pcmsk) begin
                pcmsk_q <= bus_in & PINMASK;
            end
            if (change_event) begin
                pcif_q <= 1'b1;
            end else if (pcif_clear) begin
                pcif_q <= 1'b0;
            end
        end
    end
`else
    assign pcmsk_q = '0;
    assign pcif_q  = 1'b0;
`endif

    assign irq = pcif_q;

    // Read mux. bus_out is forced to 0 while reset is active.
    // PIN is the only register that is read through the inversion mask.
    always_comb begin
        bus_out = '0;
        if (rd && rst) begin
            if (sel_port) begin
                bus_out = port_q & PINMASK;
            end else if (sel_ddr) begin
                bus_out = ddr_q & PINMASK;
            end else if (sel_pin) begin
                bus_out = (pin_q ^ INVERSE_MASK) & PINMASK;
            end else if (sel_pcmsk) begin
                bus_out = pcmsk_q & PINMASK;
            end else if (sel_pcifr) begin
                bus_out = {{(PORT_WIDTH-1){1'b0}}, pcif_q};
            end
        end
    end

    assign pio_out_io_connect = ddr_q & PINMASK & OUT_ENABLED_MASK;

    // A pad is driven only where its enable is set; other pads float.
    for (genvar i = 0; i < PORT_WIDTH; i++) begin : g_pad
        assign io_out[i] = pio_out_io_connect[i] ? (port_q[i] ^ INVERSE_MASK[i]) : 1'bz;
    end

endmodule

// File: tb/tb_atmega_pio_pcint.sv
// ---------------------------------------------------------------------------
// tb_atmega_pio_pcint
//
// Directed testbench for atmega_pio_pcint. Two instances share one bus and
// one set of pad inputs:
//   dut   : all pins implemented, no inversion, PORT resets to 'hA5
//   dut_m : PINMASK 'h0F, INVERSE_MASK 'h01
// The expected values are computed by hand. They follow the
// ATMEGA_PIO_PCINT_EN build selection.
// ---------------------------------------------------------------------------
module tb_atmega_pio_pcint;

    logic       clk;
    logic       rst;
    logic [7:0] addr;
    logic       wr;
    logic       rd;
    logic [7:0] bus_in;
    logic [7:0] io_in;
    logic       irq_ack;

    logic [7:0] bus_out;
    wire  [7:0] io_out;
    logic [7:0] oe;
    logic       irq;

    logic [7:0] bus_out_m;
    wire  [7:0] io_out_m;
    logic [7:0] oe_m;
    logic       irq_m;

    int checks;
    int failures;

    atmega_pio_pcint #(
        .INITIAL_OUTPUT_VALUE(8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .addr(addr),
        .wr(wr),
        .rd(rd),
        .bus_in(bus_in),
        .bus_out(bus_out),
        .io_in(io_in),
        .io_out(io_out),
        .pio_out_io_connect(oe),
        .irq(irq),
        .irq_ack(irq_ack)
    );

    atmega_pio_pcint #(
        .PINMASK(8'h0F),
        .INVERSE_MASK(8'h01)
    ) dut_m (
        .clk(clk),
        .rst(rst),
        .addr(addr),
        .wr(wr),
        .rd(rd),
        .bus_in(bus_in),
        .bus_out(bus_out_m),
        .io_in(io_in),
        .io_out(io_out_m),
        .pio_out_io_connect(oe_m),
        .irq(irq_m),
        .irq_ack(irq_ack)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Performs a one-cycle write strobe. It is called just after a falling
    // edge and returns just after the next falling edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d);
        addr   = a;
        bus_in = d;
        wr     = 1'b1;
        @(negedge clk);
        wr     = 1'b0;
        bus_in = 8'h00;
    endtask

    // Performs a combinational read of both instances, midway through the
    // low phase of the clock.
    task automatic readReg(input logic [7:0] a, output logic [7:0] d, output logic [7:0] dm);
        addr = a;
        rd   = 1'b1;
        #1;
        d    = bus_out;
        dm   = bus_out_m;
        rd   = 1'b0;
        #1;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    logic [7:0] r;
    logic [7:0] rm;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        addr     = 8'h00;
        wr       = 1'b0;
        rd       = 1'b0;
        bus_in   = 8'h00;
        io_in    = 8'h00;
        irq_ack  = 1'b0;

        // Reset held low: no reads, no drivers, no interrupt.
        waitCycles(2);
        readReg(8'h20, r, rm);
        checkOutput("rst_bus_out", r, 8'h00);
        checkOutput("rst_oe", oe, 8'h00);
        checkOutput("rst_irq", irq, 1'b0);

        rst = 1'b1;
        waitCycles(1);
        readReg(8'h20, r, rm);
        checkOutput("rst_port", r, 8'hA5);
        readReg(8'h23, r, rm);
        checkOutput("rst_ddr", r, 8'h00);

        // DDR, then PORT, then a PIN-write toggle.
        applyStimulus(8'h23, 8'hFF);
        applyStimulus(8'h20, 8'h3C);
        applyStimulus(8'h24, 8'h0F);
        readReg(8'h20, r, rm);
        checkOutput("toggle_port", r, 8'h33);
        checkOutput("toggle_port_m", rm, 8'h03);
        checkOutput("toggle_io_out", io_out, 8'h33);
        checkOutput("toggle_oe", oe, 8'hFF);
        checkOutput("oe_m", oe_m, 8'h0F);
        checkOutput("io_out_m_low", {28'h0, io_out_m[3:0]}, 32'h2);
        readReg(8'h23, r, rm);
        checkOutput("ddr_masked_m", rm, 8'h0F);
        applyStimulus(8'h24, 8'hC3);
        readReg(8'h20, r, rm);
        checkOutput("toggle2_port", r, 8'hF0);

        // Input synchroniser latency: the PIN read changes after the
        // second rising edge.
        io_in = 8'hF0;
        waitCycles(1);
        readReg(8'h24, r, rm);
        checkOutput("pin_lat1", r, 8'h00);
        waitCycles(1);
        readReg(8'h24, r, rm);
        checkOutput("pin_lat2", r, 8'hF0);
        checkOutput("pin_inv_m", rm, 8'h01);
        io_in = 8'hF1;
        waitCycles(2);
        readReg(8'h24, r, rm);
        checkOutput("pin_inv_m2", rm, 8'h00);
        io_in = 8'hF0;
        waitCycles(3);

`ifdef ATMEGA_PIO_PCINT_EN
        applyStimulus(8'h25, 8'h04);
        readReg(8'h25, r, rm);
        checkOutput("pcmsk_read", r, 8'h04);
        // A rising edge on masked bit 2 sets irq after edge N+2.
        io_in = 8'hF4;
        waitCycles(2);
        checkOutput("irq_n1", irq, 1'b0);
        waitCycles(1);
        checkOutput("irq_n2", irq, 1'b1);
        readReg(8'h26, r, rm);
        checkOutput("pcifr_read", r, 8'h01);
        applyStimulus(8'h26, 8'h01);
        checkOutput("pcifr_clear", irq, 1'b0);
        // Bit 3 is not in the mask, so toggling it raises no interrupt.
        io_in = 8'hFC;
        waitCycles(4);
        checkOutput("unmasked_no_irq", irq, 1'b0);
        // Set the flag again, then acknowledge it in the same cycle as a
        // new change event.
        io_in = 8'hF8;
        waitCycles(3);
        checkOutput("irq_again", irq, 1'b1);
        io_in = 8'hFC;
        waitCycles(2);
        irq_ack = 1'b1;
        waitCycles(1);
        irq_ack = 1'b0;
        checkOutput("ack_vs_event", irq, 1'b1);
        irq_ack = 1'b1;
        waitCycles(1);
        irq_ack = 1'b0;
        checkOutput("ack_alone", irq, 1'b0);
`else
        applyStimulus(8'h25, 8'hFF);
        readReg(8'h25, r, rm);
        checkOutput("pcmsk_disabled", r, 8'h00);
        io_in = 8'h0F;
        waitCycles(4);
        checkOutput("irq_disabled", irq, 1'b0);
        readReg(8'h26, r, rm);
        checkOutput("pcifr_disabled", r, 8'h00);
`endif

        // Asserting reset mid-operation clears state without a clock edge.
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_oe", oe, 8'h00);
        checkOutput("async_rst_irq", irq, 1'b0);
        rst = 1'b1;
        waitCycles(1);
        readReg(8'h20, r, rm);
        checkOutput("async_rst_port", r, 8'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
